pc_seq_ctrl: RTL and testbench

- Multi-cycle instruction sequencer for the single-issue RV32 core: owns the PC register and the fetch request/response handshake to the IFU.
- Holds each fetched instruction for the execute stage, then applies the branch unit's PC-A/PC-B selects or an override redirect to form the next PC.
- Sits between the IFU bus port and the decode/execute datapath; the branch control unit feeds pca_sel/pcb_sel.

---
 rtl/pc_seq_ctrl_pkg.sv | 19 +
 rtl/pc_seq_ctrl_next.sv | 31 +++
 rtl/pc_seq_ctrl.sv | 109 ++++++++++
 tb/tb_pc_seq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_ctrl_pkg.sv
// rtl/pc_seq_ctrl_pkg.sv - shared types and constants for the PC sequencer
package pc_seq_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_REQ  = 3'd0,
    ST_WAIT = 3'd1,
    ST_EXEC = 3'd2,
    ST_HALT = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  localparam logic [1:0] CAUSE_NONE     = 2'b00;
  localparam logic [1:0] CAUSE_FETCH    = 2'b01;
  localparam logic [1:0] CAUSE_MISALIGN = 2'b10;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h8000_0000;
  localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/pc_seq_ctrl_next.sv
// rtl/pc_seq_ctrl_next.sv - combinational next-PC target and alignment check
module pc_next_calc
  import pc_seq_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] imm,
  input  logic            pca_sel,
  input  logic            pcb_sel,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] target,
  output logic            misaligned
);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] offset;
  logic [XLEN-1:0] raw;

  always_comb begin
    base   = pcb_sel ? rs1 : pc;
    offset = pca_sel ? imm : XLEN'(PC_INC);
    raw    = redirect_valid ? redirect_pc : (base + offset);
    // bit0 is always dropped (JALR rule); bit1 set means a half-word target
    target     = {raw[XLEN-1:1], 1'b0};
    misaligned = raw[1];
  end

endmodule

// File: rtl/pc_seq_ctrl.sv
// rtl/pc_seq_ctrl.sv - multi-cycle fetch/execute sequencer owning the PC
module pc_seq_ctrl
  import pc_seq_ctrl_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEFAULT),
  parameter int              CNT_W    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             ifu_req_valid,
  input  logic             ifu_req_ready,
  output logic [XLEN-1:0]  ifu_addr,
  input  logic             ifu_rsp_valid,
  input  logic [31:0]      ifu_rsp_inst,
  input  logic             ifu_rsp_err,
  output logic [31:0]      inst,
  output logic             inst_valid,
  input  logic             exe_done,
  input  logic             pca_sel,
  input  logic             pcb_sel,
  input  logic [XLEN-1:0]  imm,
  input  logic [XLEN-1:0]  rs1,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_pc,
  input  logic             halt,
  output logic [XLEN-1:0]  pc,
  output logic             halted,
  output logic             err,
  output logic [1:0]       err_cause,
  output logic [CNT_W-1:0] retire_cnt
);

  state_t          state;
  state_t          state_nxt;
  logic [XLEN-1:0] target;
  logic            misaligned;
  logic            exec_fire;
  logic            rsp_fire;

  pc_next_calc #(.XLEN(XLEN)) u_next (
    .pc             (pc),
    .rs1            (rs1),
    .imm            (imm),
    .pca_sel        (pca_sel),
    .pcb_sel        (pcb_sel),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .target         (target),
    .misaligned     (misaligned)
  );

  assign exec_fire = (state == ST_EXEC) && exe_done;
  assign rsp_fire  = (state == ST_WAIT) && ifu_rsp_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_REQ;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_REQ:  if (ifu_req_ready) state_nxt = ST_WAIT;
      ST_WAIT: if (ifu_rsp_valid) state_nxt = ifu_rsp_err ? ST_ERR : ST_EXEC;
      ST_EXEC: begin
        if (exe_done) begin
          if (halt)            state_nxt = ST_HALT;
          else if (misaligned) state_nxt = ST_ERR;
          else                 state_nxt = ST_REQ;
        end
      end
      ST_HALT: state_nxt = ST_HALT;
      ST_ERR:  state_nxt = ST_ERR;
      // unreachable encodings park in the error trap
      default: state_nxt = ST_ERR;
    endcase
  end

  always_comb begin
    ifu_req_valid = (state == ST_REQ);
    inst_valid    = (state == ST_EXEC);
    halted        = (state == ST_HALT);
    err           = (state == ST_ERR);
    ifu_addr      = pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc         <= RESET_PC;
      inst       <= 32'd0;
      err_cause  <= CAUSE_NONE;
      retire_cnt <= '0;
    end else begin
      if (rsp_fire) begin
        if (ifu_rsp_err) err_cause <= CAUSE_FETCH;
        else             inst      <= ifu_rsp_inst;
      end
      if (exec_fire) begin
        retire_cnt <= retire_cnt + 1'b1;
        if (!halt) begin
          if (misaligned) err_cause <= CAUSE_MISALIGN;
          else            pc        <= target;
        end
      end
    end
  end

endmodule

// File: tb/tb_pc_seq_ctrl.sv
// tb/tb_pc_seq_ctrl.sv - self-checking bench for pc_seq_ctrl
module tb_pc_seq_ctrl;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ifu_req_valid;
  logic        ifu_req_ready;
  logic [31:0] ifu_addr;
  logic        ifu_rsp_valid;
  logic [31:0] ifu_rsp_inst;
  logic        ifu_rsp_err;
  logic [31:0] inst;
  logic        inst_valid;
  logic        exe_done;
  logic        pca_sel;
  logic        pcb_sel;
  logic [31:0] imm;
  logic [31:0] rs1;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic [31:0] pc;
  logic        halted;
  logic        err;
  logic [1:0]  err_cause;
  logic [63:0] retire_cnt;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  logic [31:0] exp_pc;
  logic [63:0] exp_cnt;
  logic [31:0] exp_inst;

  pc_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_inst(ifu_rsp_inst), .ifu_rsp_err(ifu_rsp_err),
    .inst(inst), .inst_valid(inst_valid), .exe_done(exe_done),
    .pca_sel(pca_sel), .pcb_sel(pcb_sel), .imm(imm), .rs1(rs1),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
    .pc(pc), .halted(halted), .err(err), .err_cause(err_cause), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic idle_inputs();
    ifu_req_ready = 0; ifu_rsp_valid = 0; ifu_rsp_inst = 0; ifu_rsp_err = 0;
    exe_done = 0; pca_sel = 0; pcb_sel = 0; imm = 0; rs1 = 0;
    redirect_valid = 0; redirect_pc = 0; halt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1;
    exp_pc = RPC; exp_cnt = 0; exp_inst = 0;
  endtask

  // Fetch one instruction; noise on execute-side inputs must have no effect.
  task automatic fetch(input logic [31:0] word, input int rdy_dly, input int rsp_dly, input logic berr);
    checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== exp_pc) begin errors++;
      $display("FAIL req_entry valid=%b addr=%h expected valid=1 addr=%h", ifu_req_valid, ifu_addr, exp_pc); end
    for (int i = 0; i < rdy_dly; i++) begin
      exe_done = 1'($urandom); halt = 1'($urandom); redirect_valid = 1'($urandom);
      ifu_rsp_valid = 1'($urandom); ifu_rsp_err = 1'($urandom); ifu_rsp_inst = $urandom;
      @(negedge clk);
      checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== exp_pc || inst !== exp_inst) begin errors++;
        $display("FAIL req_hold valid=%b addr=%h inst=%h expected 1 %h %h", ifu_req_valid, ifu_addr, inst, exp_pc, exp_inst); end
      checks++; if (retire_cnt !== exp_cnt) begin errors++;
        $display("FAIL req_noise_cnt got %0d expected %0d", retire_cnt, exp_cnt); end
    end
    idle_inputs();
    ifu_req_ready = 1;
    @(negedge clk);
    ifu_req_ready = 0;
    checks++; if (ifu_req_valid !== 1'b0 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL wait_state req_valid=%b inst_valid=%b expected 0 0", ifu_req_valid, inst_valid); end
    for (int i = 0; i < rsp_dly; i++) begin
      exe_done = 1'($urandom); halt = 1'($urandom); ifu_req_ready = 1'($urandom);
      @(negedge clk);
      checks++; if (ifu_req_valid !== 1'b0 || retire_cnt !== exp_cnt) begin errors++;
        $display("FAIL wait_hold req_valid=%b cnt=%0d expected 0 %0d", ifu_req_valid, retire_cnt, exp_cnt); end
    end
    idle_inputs();
    ifu_rsp_valid = 1; ifu_rsp_inst = word; ifu_rsp_err = berr;
    @(negedge clk);
    idle_inputs();
    if (!berr) exp_inst = word;
    checks++; if (inst !== exp_inst) begin errors++;
      $display("FAIL inst_latch got %h expected %h", inst, exp_inst); end
    if (berr) begin
      checks++; if (err !== 1'b1 || err_cause !== 2'b01 || ifu_req_valid !== 1'b0) begin errors++;
        $display("FAIL fetch_err err=%b cause=%b req=%b expected 1 01 0", err, err_cause, ifu_req_valid); end
    end else begin
      checks++; if (inst_valid !== 1'b1) begin errors++;
        $display("FAIL exec_entry inst_valid=%b expected 1", inst_valid); end
    end
  endtask

  // outcome: 0 next fetch, 1 halted, 2 misaligned error
  task automatic exec(input logic pa, input logic pb, input logic [31:0] im, input logic [31:0] r1,
                      input logic rv, input logic [31:0] rp, input logic hl, input int dly, output int outcome);
    logic [31:0] t;
    for (int i = 0; i < dly; i++) begin
      halt = 1'($urandom); redirect_valid = 1'($urandom); ifu_req_ready = 1'($urandom);
      @(negedge clk);
      checks++; if (inst_valid !== 1'b1 || pc !== exp_pc || retire_cnt !== exp_cnt) begin errors++;
        $display("FAIL exec_wait inst_valid=%b pc=%h cnt=%0d expected 1 %h %0d", inst_valid, pc, retire_cnt, exp_pc, exp_cnt); end
    end
    idle_inputs();
    pca_sel = pa; pcb_sel = pb; imm = im; rs1 = r1;
    redirect_valid = rv; redirect_pc = rp; halt = hl; exe_done = 1;
    @(negedge clk);
    idle_inputs();
    exp_cnt = exp_cnt + 1;
    if (hl) outcome = 1;
    else begin
      t = rv ? rp : ((pb ? r1 : exp_pc) + (pa ? im : 32'd4));
      t = t & 32'hFFFF_FFFE;
      if (t % 4 != 0) outcome = 2;
      else begin outcome = 0; exp_pc = t; end
    end
    checks++; if (retire_cnt !== exp_cnt) begin errors++;
      $display("FAIL retire_cnt got %0d expected %0d", retire_cnt, exp_cnt); end
    checks++; if (pc !== exp_pc) begin errors++;
      $display("FAIL exec_pc got %h expected %h", pc, exp_pc); end
    case (outcome)
      0: begin checks++; if (ifu_req_valid !== 1'b1 || ifu_addr !== exp_pc || inst_valid !== 1'b0) begin errors++;
           $display("FAIL next_req valid=%b addr=%h expected 1 %h", ifu_req_valid, ifu_addr, exp_pc); end end
      1: begin checks++; if (halted !== 1'b1 || err !== 1'b0 || ifu_req_valid !== 1'b0) begin errors++;
           $display("FAIL halt_state halted=%b err=%b req=%b expected 1 0 0", halted, err, ifu_req_valid); end end
      default: begin checks++; if (err !== 1'b1 || err_cause !== 2'b10 || ifu_req_valid !== 1'b0) begin errors++;
           $display("FAIL misalign err=%b cause=%b req=%b expected 1 10 0", err, err_cause, ifu_req_valid); end end
    endcase
  endtask

  task automatic test_terminal_hold(input int n, input logic exp_h, input logic [1:0] exp_c);
    for (int i = 0; i < n; i++) begin
      ifu_req_ready = 1'($urandom); ifu_rsp_valid = 1'($urandom); exe_done = 1'($urandom);
      halt = 1'($urandom); redirect_valid = 1'($urandom); redirect_pc = $urandom;
      @(negedge clk);
      checks++; if (ifu_req_valid !== 1'b0 || halted !== exp_h || err !== !exp_h || err_cause !== exp_c
                    || pc !== exp_pc || retire_cnt !== exp_cnt || inst_valid !== 1'b0) begin errors++;
        $display("FAIL terminal req=%b halted=%b err=%b cause=%b pc=%h cnt=%0d expected 0 %b %b %b %h %0d",
                 ifu_req_valid, halted, err, err_cause, pc, retire_cnt, exp_h, !exp_h, exp_c, exp_pc, exp_cnt); end
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if (pc !== RPC || ifu_addr !== RPC || ifu_req_valid !== 1'b1) begin errors++;
      $display("FAIL reset_pc pc=%h addr=%h req=%b expected %h %h 1", pc, ifu_addr, ifu_req_valid, RPC, RPC); end
    checks++; if (retire_cnt !== 64'd0 || inst !== 32'd0 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL reset_regs cnt=%0d inst=%h inst_valid=%b expected 0 0 0", retire_cnt, inst, inst_valid); end
    checks++; if (halted !== 1'b0 || err !== 1'b0 || err_cause !== 2'b00) begin errors++;
      $display("FAIL reset_status halted=%b err=%b cause=%b expected 0 0 00", halted, err, err_cause); end
  endtask

  task automatic test_basic();
    int o; int c0;
    c0 = cyc;
    fetch(32'h0000_0013, 0, 0, 0);
    exec(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, o);
    checks++; if (ifu_addr !== 32'h8000_0004 || retire_cnt !== 64'd1) begin errors++;
      $display("FAIL basic addr=%h cnt=%0d expected 80000004 1", ifu_addr, retire_cnt); end
    checks++; if (cyc - c0 != 3) begin errors++;
      $display("FAIL cpi got %0d expected 3", cyc - c0); end
  endtask

  task automatic test_ready_stall();
    int o;
    fetch(32'h0010_0093, 5, 1, 0);
    exec(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 2, o);
    checks++; if (ifu_addr !== 32'h8000_0008) begin errors++;
      $display("FAIL stall_next addr=%h expected 80000008", ifu_addr); end
  endtask

  task automatic test_branch();
    int o;
    repeat (2) begin fetch($urandom, 0, 0, 0); exec(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, o); end
    checks++; if (pc !== 32'h8000_0010) begin errors++;
      $display("FAIL branch_setup pc=%h expected 80000010", pc); end
    fetch(32'hFE00_0CE3, 0, 0, 0);
    exec(1, 0, 32'hFFFF_FFF8, $urandom, 0, 32'h0, 0, 1, o);
    checks++; if (ifu_addr !== 32'h8000_0008) begin errors++;
      $display("FAIL branch_taken addr=%h expected 80000008", ifu_addr); end
  endtask

  task automatic test_jalr();
    int o;
    fetch(32'h0030_8067, 0, 0, 0);
    exec(1, 1, 32'd3, 32'h8000_1001, 0, 32'h0, 0, 0, o);
    checks++; if (ifu_addr !== 32'h8000_1004) begin errors++;
      $display("FAIL jalr addr=%h expected 80001004", ifu_addr); end
    fetch(32'h0010_8067, 0, 0, 0);
    exec(1, 1, 32'd1, 32'h8000_1001, 0, 32'h0, 0, 0, o);
    checks++; if (err_cause !== 2'b10 || pc !== 32'h8000_1004) begin errors++;
      $display("FAIL jalr_misalign cause=%b pc=%h expected 10 80001004", err_cause, pc); end
    test_terminal_hold(6, 1'b0, 2'b10);
  endtask

  task automatic test_priority();
    int o;
    do_reset();
    fetch(32'h0010_0073, 0, 0, 0);
    exec(1, 1, 32'h40, 32'h100, 1, 32'h8000_0100, 1, 0, o);
    checks++; if (halted !== 1'b1 || pc !== 32'h8000_0000 || retire_cnt !== 64'd1) begin errors++;
      $display("FAIL halt_prio halted=%b pc=%h cnt=%0d expected 1 80000000 1", halted, pc, retire_cnt); end
    test_terminal_hold(5, 1'b1, 2'b00);
    do_reset();
    fetch(32'h3020_0073, 0, 0, 0);
    exec(1, 0, 32'h0000_0020, 32'h0, 1, 32'h8000_0100, 0, 0, o);
    checks++; if (ifu_addr !== 32'h8000_0100) begin errors++;
      $display("FAIL redirect addr=%h expected 80000100", ifu_addr); end
  endtask

  task automatic test_fetch_err();
    int o;
    do_reset();
    fetch(32'h1234_5678, 0, 0, 0);
    exec(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, o);
    fetch(32'hDEAD_BEEF, 1, 2, 1);
    checks++; if (inst !== 32'h1234_5678) begin errors++;
      $display("FAIL err_inst inst=%h expected 12345678", inst); end
    test_terminal_hold(5, 1'b0, 2'b01);
  endtask

  task automatic test_reset_mid_exec();
    int o;
    do_reset();
    fetch(32'h0000_0013, 0, 0, 0);
    exec(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, o);
    fetch(32'h0000_0013, 0, 0, 0);
    #2 rst_n = 0;
    #1;
    checks++; if (pc !== RPC || retire_cnt !== 64'd0 || err !== 1'b0 || ifu_req_valid !== 1'b1 || inst_valid !== 1'b0) begin errors++;
      $display("FAIL async_reset pc=%h cnt=%0d err=%b req=%b inst_valid=%b expected %h 0 0 1 0",
               pc, retire_cnt, err, ifu_req_valid, inst_valid, RPC); end
    @(negedge clk);
    rst_n = 1;
    exp_pc = RPC; exp_cnt = 0; exp_inst = 0;
    fetch(32'h0000_0013, 0, 0, 0);
    exec(0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 0, o);
  endtask

  task automatic test_random();
    int o;
    logic berr;
    logic [31:0] im;
    do_reset();
    for (int n = 0; n < 150; n++) begin
      berr = ($urandom_range(0, 19) == 0);
      fetch($urandom, $urandom_range(0, 3), $urandom_range(0, 3), berr);
      if (berr) begin
        test_terminal_hold(2, 1'b0, 2'b01);
        do_reset();
      end else begin
        im = ($urandom_range(0, 3) == 0) ? $urandom : (($urandom & 32'h0000_0FFC) - 32'h800);
        exec(1'($urandom), 1'($urandom), im, $urandom, ($urandom_range(0, 9) == 0), $urandom,
             ($urandom_range(0, 29) == 0), $urandom_range(0, 2), o);
        if (o == 1)      begin test_terminal_hold(2, 1'b1, 2'b00); do_reset(); end
        else if (o == 2) begin test_terminal_hold(2, 1'b0, 2'b10); do_reset(); end
      end
    end
  endtask

  initial begin
    rst_n = 1;
    idle_inputs();
    test_reset();
    test_basic();
    test_ready_stall();
    test_branch();
    test_jalr();
    test_priority();
    test_fetch_err();
    test_reset_mid_exec();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
